// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake to
// instruction memory, and buffers one instruction for the IF/ID register.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   stall            data hazard; IF/ID does not consume this cycle
//   redirect         control hazard; flush and refetch from redirectPC
//   redirectPC       branch/jump target
//   imemReq/imemAddr memory request and address, stable until acked
//   imemAck/imemData memory returns imemData in the ack cycle
//   pcOut/insnOut    buffered PC and instruction (0 when empty)
//   validOut         buffer holds a real instruction
module fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectPC,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [INSN_W-1:0] imemData,
  output logic [ADDR_W-1:0] pcOut,
  output logic [INSN_W-1:0] insnOut,
  output logic              validOut
);

  typedef enum logic [1:0] {
    READY = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   drain_q, drain_d;
  logic                bv_q, bv_d;
  logic [ADDR_W-1:0]   bpc_q, bpc_d;
  logic [INSN_W-1:0]   bin_q, bin_d;
  logic                req_c;
  logic [ADDR_W-1:0]   addr_c;
  logic                acc_c;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    bv_d    = bv_q;
    bpc_d   = bpc_q;
    bin_d   = bin_q;
    req_c   = 1'b1;
    addr_c  = pc_q;
    unique case (state_q)
      READY:   req_c = !bv_q || !stall;
      DRAIN:   addr_c = drain_q;
      default: req_c = 1'b1;
    endcase
    // DRAIN acks return data of a flushed request
    acc_c = req_c && imemAck && (state_q != DRAIN);

    if (redirect) begin
      pc_d = redirectPC;
      bv_d = 1'b0;
      if (req_c && !imemAck) begin
        drain_d = addr_c;
        state_d = DRAIN;
      end else begin
        state_d = READY;
      end
    end else begin
      unique case (state_q)
        READY:   if (req_c && !imemAck) state_d = WAIT;
        WAIT:    if (imemAck) state_d = READY;
        DRAIN:   if (imemAck) state_d = READY;
        default: state_d = READY;
      endcase
      if (acc_c) begin
        bv_d  = 1'b1;
        bpc_d = addr_c;
        bin_d = imemData;
        pc_d  = pc_q + ADDR_W'(PC_STEP);
      end else if (!stall) begin
        bv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= READY;
      pc_q    <= RESET_PC;
      drain_q <= '0;
      bv_q    <= 1'b0;
      bpc_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      bv_q    <= bv_d;
      bpc_q   <= bpc_d;
      bin_q   <= bin_d;
    end
  end

  // request is forced low while reset is held
  assign imemReq  = rst && req_c;
  assign imemAddr = addr_c;
  assign validOut = bv_q;
  assign pcOut    = bv_q ? bpc_q : '0;
  assign insnOut  = bv_q ? bin_q : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed per-cycle vectors for fetch_unit: inputs driven after the
// falling edge, all outputs compared 1ns later within the same cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] pcOut;
  logic [31:0] insnOut;
  logic        validOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect(redirect), .redirectPC(redirectPC),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData),
    .pcOut(pcOut), .insnOut(insnOut),
    .validOut(validOut)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] insn;
  } vec_t;

  localparam int N = 24;
  vec_t tbl [N];

  function automatic vec_t mk(
    logic r, logic s, logic rd, logic [31:0] rp,
    logic a, logic [31:0] d, logic q,
    logic [31:0] ad, logic v, logic [31:0] p,
    logic [31:0] i);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rd;
    t.rpc = rp; t.ack = a; t.data = d;
    t.req = q; t.addr = ad; t.vld = v;
    t.pc = p; t.insn = i;
    return t;
  endfunction

  task automatic chk(string nm, int idx,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; stall = v.stall;
    redirect = v.redir; redirectPC = v.rpc;
    imemAck = v.ack; imemData = v.data;
  endtask

  task automatic cmp(vec_t v, int idx);
    chk("imemReq", idx, 32'(imemReq), 32'(v.req));
    chk("imemAddr", idx, imemAddr, v.addr);
    chk("validOut", idx, 32'(validOut), 32'(v.vld));
    chk("pcOut", idx, pcOut, v.pc);
    chk("insnOut", idx, insnOut, v.insn);
  endtask

  task automatic step(vec_t v, int idx);
    @(negedge clk);
    drive(v);
    #1;
    cmp(v, idx);
  endtask

  initial begin
    //            rst s rd rpc     ack data      req addr     v pc      insn
    // zero-wait fetch after reset
    tbl[0]  = mk(1,0,0,0,      1,32'h100, 1,32'h0,  0,32'h0, 32'h0);
    tbl[1]  = mk(1,0,0,0,      1,32'h104, 1,32'h4,  1,32'h0, 32'h100);
    tbl[2]  = mk(1,0,0,0,      1,32'h108, 1,32'h8,  1,32'h4, 32'h104);
    // stall 4 cycles holding pc 0x8
    tbl[3]  = mk(1,1,0,0,      0,32'h0,   0,32'hC,  1,32'h8, 32'h108);
    tbl[4]  = mk(1,1,0,0,      0,32'h0,   0,32'hC,  1,32'h8, 32'h108);
    tbl[5]  = mk(1,1,0,0,      0,32'h0,   0,32'hC,  1,32'h8, 32'h108);
    tbl[6]  = mk(1,1,0,0,      0,32'h0,   0,32'hC,  1,32'h8, 32'h108);
    tbl[7]  = mk(1,0,0,0,      1,32'h10C, 1,32'hC,  1,32'h8, 32'h108);
    // redirect to 0x40 with 0x10 outstanding, stale ack 0xDEAD
    tbl[8]  = mk(1,0,1,32'h40, 0,32'h0,   1,32'h10, 1,32'hC, 32'h10C);
    tbl[9]  = mk(1,0,0,0,      0,32'h0,   1,32'h10, 0,32'h0, 32'h0);
    tbl[10] = mk(1,0,0,0,      1,32'hDEAD,1,32'h10, 0,32'h0, 32'h0);
    tbl[11] = mk(1,0,0,0,      1,32'h140, 1,32'h40, 0,32'h0, 32'h0);
    tbl[12] = mk(1,0,0,0,      1,32'h144, 1,32'h44, 1,32'h40,32'h140);
    // redirect to 0x80 coinciding with an ack
    tbl[13] = mk(1,0,1,32'h80, 1,32'h148, 1,32'h48, 1,32'h44,32'h144);
    tbl[14] = mk(1,0,0,0,      1,32'h180, 1,32'h80, 0,32'h0, 32'h0);
    tbl[15] = mk(1,0,0,0,      0,32'h0,   1,32'h84, 1,32'h80,32'h180);
    // reset, then 3-cycle ack latency
    tbl[16] = mk(0,0,0,0,      0,32'h0,   0,32'h0,  0,32'h0, 32'h0);
    tbl[17] = mk(1,0,0,0,      0,32'h0,   1,32'h0,  0,32'h0, 32'h0);
    tbl[18] = mk(1,0,0,0,      0,32'h0,   1,32'h0,  0,32'h0, 32'h0);
    tbl[19] = mk(1,0,0,0,      1,32'h100, 1,32'h0,  0,32'h0, 32'h0);
    tbl[20] = mk(1,0,0,0,      0,32'h0,   1,32'h4,  1,32'h0, 32'h100);
    tbl[21] = mk(1,0,0,0,      0,32'h0,   1,32'h4,  0,32'h0, 32'h0);
    tbl[22] = mk(1,0,0,0,      1,32'h104, 1,32'h4,  0,32'h0, 32'h0);
    tbl[23] = mk(1,0,0,0,      0,32'h0,   1,32'h8,  1,32'h4, 32'h104);

    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirectPC = '0; imemAck = 1'b0; imemData = '0;
    #2;
    chk("rst_req", -1, 32'(imemReq), 32'h0);
    chk("rst_valid", -1, 32'(validOut), 32'h0);
    chk("rst_pc", -1, pcOut, 32'h0);
    chk("rst_insn", -1, insnOut, 32'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < N; i++) step(tbl[i], i);

    // wrap from the top address, then reset mid-WAIT
    step(mk(1,0,1,32'hFFFF_FFFC,0,32'h0,
            1,32'h8,0,32'h0,32'h0), 100);
    step(mk(1,0,0,0,1,32'h0,
            1,32'h8,0,32'h0,32'h0), 101);
    step(mk(1,0,0,0,1,32'hAAAA,
            1,32'hFFFF_FFFC,0,32'h0,32'h0), 102);
    step(mk(1,0,0,0,1,32'hBBBB,
            1,32'h0,1,32'hFFFF_FFFC,32'hAAAA), 103);
    step(mk(1,0,0,0,0,32'h0,
            1,32'h4,1,32'h0,32'hBBBB), 104);
    step(mk(1,0,0,0,0,32'h0,
            1,32'h4,0,32'h0,32'h0), 105);
    #1 rst = 1'b0;
    #1;
    chk("midrst_req", 106, 32'(imemReq), 32'h0);
    chk("midrst_addr", 106, imemAddr, 32'h0);
    chk("midrst_valid", 106, 32'(validOut), 32'h0);
    step(mk(1,0,0,0,1,32'h100,
            1,32'h0,0,32'h0,32'h0), 107);
    step(mk(1,0,0,0,0,32'h0,
            1,32'h4,1,32'h0,32'h100), 108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
